// File: rtl/snes_romload_sink.sv
// Generic FIFO: first-word-fall-through storage with a synchronous clear; DEPTH must be a power of two.
// Latency: a pushed entry is visible at dout the cycle after the push.
// Backpressure: a push while full is dropped and a pop while empty is ignored; the caller flags the loss.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// SNES ROM load sink: parses the 64-byte header, packs the payload into 16-bit SDRAM writes from word 0.
// Latency: a completed word reaches mem_wr three cycles after its odd byte; one idle cycle between writes.
// Backpressure: mem_wait holds the presented write; FIFO overrun or oversize payload drops data and sets overflow. Optional ROMLOAD_CHECKSUM_EN adds checksum outputs.
module snes_romload_sink #(
    parameter int          FIFO_DEPTH = 8,
    parameter int unsigned MAX_BYTES  = 8388608
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rom_loading,
    input  logic [7:0]  rom_do,
    input  logic        rom_do_valid,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_ds,
    output logic        mem_wr,
    input  logic        mem_wait,
    output logic [7:0]  map_mode,
    output logic [7:0]  rom_type,
    output logic [7:0]  rom_size,
    output logic [7:0]  ram_size,
    output logic [15:0] reset_vec,
    output logic [23:0] rom_bytes,
    output logic [22:0] rom_mask,
    output logic        busy,
    output logic        done,
    output logic        overflow
`ifdef ROMLOAD_CHECKSUM_EN
    ,
    output logic [15:0] checksum,
    output logic        checksum_ok
`endif
);
    typedef enum logic [2:0] {IDLE, HEADER, DATA, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [21:0] addr;
        logic [15:0] dat;
        logic [1:0]  ds;
    } wr_ent_t;

    state_t      state;
    logic        loading_q;
    logic [5:0]  hdr_cnt;
    logic [7:0]  pair_lo;
    logic        pair_pend;
    logic        wq_vld;
    wr_ent_t     wq_dat;
    wr_ent_t     head_dat;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_clr;
    logic        fifo_pop;
    logic        rise;
    logic        fall;
    logic        byte_vld;
    logic        over_max;
    logic [22:0] mask_v;
    logic [22:0] mask_calc;
`ifdef ROMLOAD_CHECKSUM_EN
    logic [15:0] hdr_comp;
    logic [15:0] hdr_sum;
`endif

    assign rise     = rom_loading && !loading_q;
    assign fall     = !rom_loading && loading_q;
    assign byte_vld = rom_do_valid && rom_loading;
    assign over_max = ({8'd0, rom_bytes} >= MAX_BYTES);
    assign fifo_clr = rise && (state == IDLE || state == DONE);
    assign fifo_pop = mem_wr && !mem_wait;

    fifo #(
        .W     ($bits(wr_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (fifo_clr),
        .push  (wq_vld),
        .din   (wq_dat),
        .pop   (fifo_pop),
        .dout  (head_dat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Mask is all ones below the top set bit of (bytes-1); a full 2^23 payload wraps to all ones.
    always_comb begin
        mask_v        = rom_bytes[22:0] - 23'd1;
        mask_calc     = '0;
        mask_calc[22] = mask_v[22];
        for (int i = 21; i >= 0; i--) mask_calc[i] = mask_calc[i+1] | mask_v[i];
        if (rom_bytes <= 24'd1) mask_calc = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            loading_q <= 1'b0;
            hdr_cnt   <= '0;
            pair_lo   <= '0;
            pair_pend <= 1'b0;
            wq_vld    <= 1'b0;
            wq_dat    <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_ds    <= '0;
            mem_wr    <= 1'b0;
            map_mode  <= '0;
            rom_type  <= '0;
            rom_size  <= '0;
            ram_size  <= '0;
            reset_vec <= '0;
            rom_bytes <= '0;
            rom_mask  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
`ifdef ROMLOAD_CHECKSUM_EN
            hdr_comp    <= '0;
            hdr_sum     <= '0;
            checksum    <= '0;
            checksum_ok <= 1'b0;
`endif
        end else begin
            loading_q <= rom_loading;
            wq_vld    <= 1'b0;
            if (wq_vld && fifo_full) overflow <= 1'b1;

            // The head entry stays in the FIFO until accepted, so an empty FIFO means nothing is owed.
            if (mem_wr) begin
                if (!mem_wait) mem_wr <= 1'b0;
            end else if (!fifo_empty) begin
                mem_wr   <= 1'b1;
                mem_addr <= head_dat.addr;
                mem_din  <= head_dat.dat;
                mem_ds   <= head_dat.ds;
            end

            case (state)
                IDLE, DONE: begin
                    if (rise) begin
                        state     <= HEADER;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        overflow  <= 1'b0;
                        rom_bytes <= '0;
                        hdr_cnt   <= '0;
                        pair_pend <= 1'b0;
`ifdef ROMLOAD_CHECKSUM_EN
                        checksum    <= '0;
                        checksum_ok <= 1'b0;
`endif
                    end
                end
                HEADER: begin
                    if (fall) begin
                        state <= FLUSH;
                    end else if (byte_vld) begin
                        case (hdr_cnt)
                            6'h15:   map_mode        <= rom_do;
                            6'h16:   rom_type        <= rom_do;
                            6'h17:   rom_size        <= rom_do;
                            6'h18:   ram_size        <= rom_do;
`ifdef ROMLOAD_CHECKSUM_EN
                            6'h1C:   hdr_comp[7:0]   <= rom_do;
                            6'h1D:   hdr_comp[15:8]  <= rom_do;
                            6'h1E:   hdr_sum[7:0]    <= rom_do;
                            6'h1F:   hdr_sum[15:8]   <= rom_do;
`endif
                            6'h3C:   reset_vec[7:0]  <= rom_do;
                            6'h3D:   reset_vec[15:8] <= rom_do;
                            default: ;
                        endcase
                        hdr_cnt <= hdr_cnt + 6'd1;
                        if (hdr_cnt == 6'd63) state <= DATA;
                    end
                end
                DATA: begin
                    if (fall) begin
                        if (pair_pend) begin
                            wq_vld    <= 1'b1;
                            wq_dat    <= '{addr: rom_bytes[22:1], dat: {8'h00, pair_lo}, ds: 2'b01};
                            pair_pend <= 1'b0;
                        end
                        state <= FLUSH;
                    end else if (byte_vld) begin
                        if (over_max) begin
                            overflow <= 1'b1;
                        end else begin
                            if (!rom_bytes[0]) begin
                                pair_lo   <= rom_do;
                                pair_pend <= 1'b1;
                            end else begin
                                wq_vld    <= 1'b1;
                                wq_dat    <= '{addr: rom_bytes[22:1], dat: {rom_do, pair_lo}, ds: 2'b11};
                                pair_pend <= 1'b0;
                            end
                            rom_bytes <= rom_bytes + 24'd1;
`ifdef ROMLOAD_CHECKSUM_EN
                            checksum  <= checksum + {8'h00, rom_do};
`endif
                        end
                    end
                end
                FLUSH: begin
                    if (fifo_empty && !wq_vld && !mem_wr) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rom_mask <= mask_calc;
`ifdef ROMLOAD_CHECKSUM_EN
                        checksum_ok <= (checksum == hdr_sum) && ((hdr_sum ^ hdr_comp) == 16'hFFFF);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
